msx_clock_reset_gen: RTL and testbench

//  Sits directly downstream of the PLL: runs on the PLL output clock (75.17 MHz CLKOUTD)
//  and consumes the asynchronous PLL lock flag. Produces a lock-qualified system reset and
//  a 3.579 MHz MSX bus clock enable/square wave regenerated by integer division.
//  All cartridge-side logic is released from reset only after the PLL is stable and
//  a fixed number of bus clocks have elapsed.

---
 rtl/msx_clock_reset_gen.sv | 133 +++++++++++++
 tb/tb_msx_clock_reset_gen.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/msx_clock_reset_gen.sv
// Lock-qualified reset sequencer and MSX bus clock divider, clocked by the PLL output.
// Holds downstream logic in reset until the PLL is stable and a number of bus clocks have run.
module msx_clock_reset_gen #(
  parameter int unsigned CLK_DIV            = 21,
  parameter int unsigned LOCK_STABLE_CYCLES = 4096,
  parameter int unsigned RESET_HOLD_CYCLES  = 256
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pll_lock_i,
  output logic sys_reset_o,
  output logic ready_o,
  output logic clk_en_o,
  output logic msx_clk_o
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
  localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned HLD_W = $clog2(RESET_HOLD_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  // sync_q[1] is the synchronized lock; pll_lock_i is asynchronous to clk_i
  logic [1:0]       sync_q;
  state_e           state_q, state_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [HLD_W-1:0] hold_q, hold_d;
  logic             clk_en_q, clk_en_d;
  logic             msx_clk_q, msx_clk_d;
  logic             sys_reset_q, sys_reset_d;
  logic             ready_q, ready_d;

  logic lock_s;
  logic abort;
  logic run_d;

  assign lock_s = sync_q[1];
  assign abort  = (state_q != WAIT_LOCK) && !lock_s;

  // State register and output registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q      <= 2'b00;
      state_q     <= WAIT_LOCK;
      stable_q    <= '0;
      div_q       <= '0;
      hold_q      <= '0;
      clk_en_q    <= 1'b0;
      msx_clk_q   <= 1'b0;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], pll_lock_i};
      state_q     <= state_d;
      stable_q    <= stable_d;
      div_q       <= div_d;
      hold_q      <= hold_d;
      clk_en_q    <= clk_en_d;
      msx_clk_q   <= msx_clk_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
    end
  end

  // Next state and counters; lock loss overrides every transition
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    div_d    = div_q;
    hold_d   = hold_q;
    if (abort) begin
      state_d  = WAIT_LOCK;
      stable_d = '0;
      div_d    = '0;
      hold_d   = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          stable_d = '0;
          div_d    = '0;
          hold_d   = '0;
          if (lock_s) state_d = STABLE;
        end
        STABLE: begin
          if (stable_q == STB_LAST) begin
            state_d = HOLD;
            div_d   = '0;
            hold_d  = '0;
          end else begin
            stable_d = stable_q + 1'b1;
          end
        end
        HOLD: begin
          div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
          if (clk_en_q) begin
            hold_d = hold_q + 1'b1;
            if (hold_q == HLD_LAST) state_d = RUN;
          end
        end
        RUN: begin
          div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  // Outputs are registered from next-state so they line up with the state they describe
  always_comb begin
    run_d       = (state_d == HOLD) || (state_d == RUN);
    clk_en_d    = run_d && (div_q == DIV_LAST);
    msx_clk_d   = run_d && (div_d < DIV_HALF);
    sys_reset_d = (state_d != RUN);
    ready_d     = (state_d == RUN);
  end

  assign sys_reset_o = sys_reset_q;
  assign ready_o     = ready_q;
  assign clk_en_o    = clk_en_q;
  assign msx_clk_o   = msx_clk_q;

endmodule

// File: tb/tb_msx_clock_reset_gen.sv
// Bench for msx_clock_reset_gen: a CLK_DIV=21 instance for the main sequences and a
// CLK_DIV=2 instance for the minimum divider and the final-pulse/lock-drop collision.
module tb_msx_clock_reset_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic lock_a, sys_reset_a, ready_a, clk_en_a, msx_a;
  logic lock_b, sys_reset_b, ready_b, clk_en_b, msx_b;

  msx_clock_reset_gen #(.CLK_DIV(21), .LOCK_STABLE_CYCLES(8), .RESET_HOLD_CYCLES(4)) dut_a (
    .clk_i(clk), .reset_i(reset), .pll_lock_i(lock_a),
    .sys_reset_o(sys_reset_a), .ready_o(ready_a), .clk_en_o(clk_en_a), .msx_clk_o(msx_a)
  );

  msx_clock_reset_gen #(.CLK_DIV(2), .LOCK_STABLE_CYCLES(8), .RESET_HOLD_CYCLES(4)) dut_b (
    .clk_i(clk), .reset_i(reset), .pll_lock_i(lock_b),
    .sys_reset_o(sys_reset_b), .ready_o(ready_b), .clk_en_o(clk_en_b), .msx_clk_o(msx_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int qa[$];
  int qb[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard: every clk_en pulse must match the next expected cycle number
  always @(negedge clk) begin
    if (clk_en_a === 1'b1) begin
      if (qa.size() == 0) chk("a_unexpected_clk_en", 1, 0);
      else                chk("a_clk_en_cycle", cyc, qa.pop_front());
    end
    if (clk_en_b === 1'b1) begin
      if (qb.size() == 0) chk("b_unexpected_clk_en", 1, 0);
      else                chk("b_clk_en_cycle", cyc, qb.pop_front());
    end
  end

  // Lock seen high from cycle c: HOLD at c+11, pulses c+32+21k, RUN at c+96
  task automatic run_seq(input string tag, input int c);
    for (int k = 0; k < 4; k++) qa.push_back(c + 32 + 21 * k);
    wait_to(c + 10); chk({tag, "_msx_pre_hold"}, int'(msx_a), 0);
    wait_to(c + 11); chk({tag, "_msx_hold_entry"}, int'(msx_a), 1);
    wait_to(c + 95); chk({tag, "_sysrst_pre_run"}, int'(sys_reset_a), 1);
                     chk({tag, "_ready_pre_run"}, int'(ready_a), 0);
    wait_to(c + 96); chk({tag, "_sysrst_run"}, int'(sys_reset_a), 0);
                     chk({tag, "_ready_run"}, int'(ready_a), 1);
  endtask

  initial begin
    int c0, d0, c1, g0, r0, b0, errs, ph;
    reset  = 1'b1;
    lock_a = 1'b0;
    lock_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sys_reset", int'(sys_reset_a), 1);
    chk("rst_ready", int'(ready_a), 0);
    chk("rst_clk_en", int'(clk_en_a), 0);
    chk("rst_msx_clk", int'(msx_a), 0);
    chk("rst_b_sys_reset", int'(sys_reset_b), 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // CLK_DIV=2: toggling bus clock, then lock lost so lock_s drops on the final pulse cycle
    b0 = cyc;
    lock_b = 1'b1;
    for (int k = 0; k < 4; k++) qb.push_back(b0 + 13 + 2 * k);
    for (int k = 0; k < 4; k++) begin
      wait_to(b0 + 11 + k);
      chk("b_msx_toggle", int'(msx_b), (k % 2 == 0) ? 1 : 0);
    end
    wait_to(b0 + 17); lock_b = 1'b0;
    wait_to(b0 + 19); chk("b_sysrst_final_pulse", int'(sys_reset_b), 1);
    wait_to(b0 + 20); chk("b_collision_sysrst", int'(sys_reset_b), 1);
                      chk("b_collision_ready", int'(ready_b), 0);
                      chk("b_collision_msx", int'(msx_b), 0);
    wait_to(b0 + 26); chk("b_stays_waiting", int'(ready_b), 0);

    // Power-up sequence
    c0 = cyc;
    lock_a = 1'b1;
    run_seq("pwr", c0);

    // 1000 pulses in RUN; phase 0..9 high, 10..20 low relative to HOLD entry
    for (int k = 1; k <= 1000; k++) qa.push_back(c0 + 95 + 21 * k);
    errs = 0;
    for (int x = c0 + 97; x <= c0 + 21095; x++) begin
      wait_to(x);
      ph = (x - (c0 + 11)) % 21;
      if (msx_a !== ((ph < 10) ? 1'b1 : 1'b0)) errs++;
    end
    chk("run_msx_phase_errs", errs, 0);

    // Lock loss in RUN: 3 clk to reset, then a full replay
    d0 = c0 + 21096;
    wait_to(d0); lock_a = 1'b0;
    wait_to(d0 + 2); chk("loss_sysrst_still_low", int'(sys_reset_a), 0);
    wait_to(d0 + 3); chk("loss_sysrst", int'(sys_reset_a), 1);
                     chk("loss_ready", int'(ready_a), 0);
                     chk("loss_clk_en", int'(clk_en_a), 0);
                     chk("loss_msx", int'(msx_a), 0);
    c1 = d0 + 5;
    wait_to(c1); lock_a = 1'b1;
    run_seq("replay", c1);

    // Lock glitch during STABLE restarts the stable count
    wait_to(c1 + 97); lock_a = 1'b0;
    g0 = c1 + 105;
    wait_to(g0);     lock_a = 1'b1;
    wait_to(g0 + 5); lock_a = 1'b0;
    wait_to(g0 + 8); lock_a = 1'b1;
    run_seq("glitch", g0 + 8);

    // One-cycle reset mid-HOLD with lock held
    wait_to(g0 + 8 + 97); lock_a = 1'b0;
    r0 = g0 + 8 + 105;
    wait_to(r0); lock_a = 1'b1;
    qa.push_back(r0 + 32);
    wait_to(r0 + 40); reset = 1'b1;
    wait_to(r0 + 41); reset = 1'b0;
    chk("midrst_sysrst", int'(sys_reset_a), 1);
    chk("midrst_ready", int'(ready_a), 0);
    chk("midrst_clk_en", int'(clk_en_a), 0);
    chk("midrst_msx", int'(msx_a), 0);
    run_seq("after_rst", r0 + 41);

    wait_to(r0 + 41 + 97); lock_a = 1'b0;
    wait_to(r0 + 41 + 105);
    chk("a_pending_pulses", qa.size(), 0);
    chk("b_pending_pulses", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
